// File: rtl/dram_march_bist_if.sv
// Control/status bundle of the March C- BIST engine: run request, fault injection
// and the sticky result registers. The engine side uses the slave modport.
interface dram_march_bist_if #(
   parameter int N_CH = 4,
   parameter int AW   = 6,
   parameter int CW   = 2
);
   // start is a level request that is accepted only while the engine is idle;
   // acceptance shows as busy rising one cycle later. done, pass and fail_* are
   // stable from the rise of done until the next accepted start.
   logic            start;
   logic            inj_en;
   logic [CW-1:0]   inj_ch;
   logic [AW-1:0]   inj_addr;
   logic            busy;
   logic            done;
   logic            pass;
   logic [N_CH-1:0] fail_mask;
   logic [AW-1:0]   fail_addr;
   logic [2:0]      fail_elem;
   logic [2:0]      fsm_state;

   modport master (
      output start, inj_en, inj_ch, inj_addr,
      input  busy, done, pass, fail_mask, fail_addr, fail_elem, fsm_state
   );

   modport slave (
      input  start, inj_en, inj_ch, inj_addr,
      output busy, done, pass, fail_mask, fail_addr, fail_elem, fsm_state
   );
endinterface

// File: rtl/dram_march_bist.sv
// N_CH single-port LUT-RAM channels (async read, sync write) sharing one address
// and write-data bus, tested in parallel by a March C- engine.
module dram_march_bist #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 1,
   parameter int N_CH  = 4
) (
   input  logic                clk,
   input  logic                rst,
   dram_march_bist_if.slave    bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

   if (DEPTH != 32 && DEPTH != 64 && DEPTH != 128 && DEPTH != 256) begin : g_bad_depth
      $error("dram_march_bist: DEPTH must be 32, 64, 128 or 256");
   end
   if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("dram_march_bist: WIDTH must be in 1..64");
   end
   if (N_CH < 1 || N_CH > 32) begin : g_bad_nch
      $error("dram_march_bist: N_CH must be in 1..32");
   end
   if (CW < 1) begin : g_bad_cw
      $error("dram_march_bist: channel index width must be at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_M0   = 3'd1,
      S_M1   = 3'd2,
      S_M2   = 3'd3,
      S_M3   = 3'd4,
      S_M4   = 3'd5,
      S_M5   = 3'd6,
      S_DONE = 3'd7
   } state_t;

   state_t          state, state_nxt;
   logic [AW-1:0]   addr, addr_nxt;
   logic            run_start, run_end;
   logic            wr_en, rd_en;
   logic [WIDTH-1:0] wr_word, exp_word;
   logic [2:0]      cur_elem;
   logic [N_CH-1:0] mism;

   logic            done_q, pass_q;
   logic [N_CH-1:0] fail_mask_q;
   logic [AW-1:0]   fail_addr_q;
   logic [2:0]      fail_elem_q;

   logic            at_top, at_bottom;
   assign at_top    = (addr == ADDR_LAST);
   assign at_bottom = (addr == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         addr  <= '0;
      end else begin
         state <= state_nxt;
         addr  <= addr_nxt;
      end
   end

   // Each element spends one cycle per address; a read-then-write pair completes
   // in that cycle because the compare uses the asynchronous read before the edge.
   always_comb begin
      state_nxt = state;
      addr_nxt  = addr;
      run_start = 1'b0;
      run_end   = 1'b0;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      wr_word   = '0;
      exp_word  = '0;
      cur_elem  = 3'd0;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               state_nxt = S_M0;
               addr_nxt  = '0;
               run_start = 1'b1;
            end
         end
         S_M0: begin
            wr_en = 1'b1;
            if (at_top) begin
               state_nxt = S_M1;
               addr_nxt  = '0;
            end else begin
               addr_nxt = addr + 1'b1;
            end
         end
         S_M1: begin
            rd_en    = 1'b1;
            wr_en    = 1'b1;
            wr_word  = '1;
            cur_elem = 3'd1;
            if (at_top) begin
               state_nxt = S_M2;
               addr_nxt  = '0;
            end else begin
               addr_nxt = addr + 1'b1;
            end
         end
         S_M2: begin
            rd_en    = 1'b1;
            wr_en    = 1'b1;
            exp_word = '1;
            cur_elem = 3'd2;
            if (at_top) begin
               state_nxt = S_M3;
               addr_nxt  = ADDR_LAST;
            end else begin
               addr_nxt = addr + 1'b1;
            end
         end
         S_M3: begin
            rd_en    = 1'b1;
            wr_en    = 1'b1;
            wr_word  = '1;
            cur_elem = 3'd3;
            if (at_bottom) begin
               state_nxt = S_M4;
               addr_nxt  = ADDR_LAST;
            end else begin
               addr_nxt = addr - 1'b1;
            end
         end
         S_M4: begin
            rd_en    = 1'b1;
            wr_en    = 1'b1;
            exp_word = '1;
            cur_elem = 3'd4;
            if (at_bottom) begin
               state_nxt = S_M5;
               addr_nxt  = ADDR_LAST;
            end else begin
               addr_nxt = addr - 1'b1;
            end
         end
         S_M5: begin
            rd_en    = 1'b1;
            cur_elem = 3'd5;
            if (at_bottom) begin
               state_nxt = S_DONE;
               run_end   = 1'b1;
            end else begin
               addr_nxt = addr - 1'b1;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
      logic [WIDTH-1:0] mem [DEPTH];
      logic [WIDTH-1:0] rd_val;

      always_ff @(posedge clk) begin
         if (wr_en) begin
            mem[addr] <= wr_word;
         end
      end

      // Injected stuck-at-1 sits on the compare path only; stored data is untouched.
      always_comb begin
         rd_val = mem[addr];
         if (bus.inj_en && (bus.inj_addr == addr) && (int'(bus.inj_ch) == ch)) begin
            rd_val[0] = 1'b1;
         end
      end

      assign mism[ch] = rd_en && (rd_val != exp_word);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_mask_q <= '0;
         fail_addr_q <= '0;
         fail_elem_q <= 3'd0;
      end else if (run_start) begin
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_mask_q <= '0;
         fail_addr_q <= '0;
         fail_elem_q <= 3'd0;
      end else begin
         if (|mism) begin
            fail_mask_q <= fail_mask_q | mism;
            if (fail_mask_q == '0) begin
               fail_addr_q <= addr;
               fail_elem_q <= cur_elem;
            end
         end
         // pass includes a mismatch caught on the final address of M5.
         if (run_end) begin
            done_q <= 1'b1;
            pass_q <= ~|(fail_mask_q | mism);
         end
      end
   end

   assign bus.busy      = (state == S_M0) || (state == S_M1) || (state == S_M2) ||
                          (state == S_M3) || (state == S_M4) || (state == S_M5);
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.fail_mask = fail_mask_q;
   assign bus.fail_addr = fail_addr_q;
   assign bus.fail_elem = fail_elem_q;
   assign bus.fsm_state = state;
endmodule
